traffic_light_fsm: RTL and testbench
====================================

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 SHALL have parameter YEL_CYCLES, default 5: yellow duration in clock cycles, legal range 1..255.
REQ-002 SHALL have parameter MIN_GREEN, default 10: minimum green duration in clock cycles, legal range 1..255.
REQ-003 SHALL have port i_clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rstn  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_TA  input  1: traffic present on street A (1 = cars waiting or passing).
REQ-006 SHALL have port i_TB  input  1: traffic present on street B.
REQ-007 SHALL have port i_M  input  1: parade mode, driven by the upstream mode FSM (1 = parade active).
REQ-008 SHALL have port o_LA  output  2: street A light; 2'b00 green, 2'b01 yellow, 2'b10 red; 2'b11 never driven.
REQ-009 SHALL have port o_LB  output  2: street B light, same encoding as o_LA.

Function
REQ-010 SHALL register i_TA, i_TB and i_M once each (TA_q, TB_q, M_q); all decisions use only the registered copies.
REQ-011 SHALL implement four states: A_GREEN, A_YELLOW, B_GREEN, B_YELLOW.
REQ-012 SHALL decode outputs as Moore outputs of state only: A_GREEN LA=00/LB=10; A_YELLOW LA=01/LB=10; B_GREEN LA=10/LB=00; B_YELLOW LA=10/LB=01.
REQ-013 SHALL keep an 8-bit dwell counter: cleared to 0 on every state transition, otherwise +1 per cycle, saturating at 255.
REQ-014 A_GREEN -> A_YELLOW SHALL occur when cnt >= MIN_GREEN-1 and TA_q == 0; otherwise hold.
REQ-015 A_YELLOW -> B_GREEN SHALL occur when cnt == YEL_CYCLES-1; yellow therefore lasts exactly YEL_CYCLES cycles.
REQ-016 B_GREEN -> B_YELLOW SHALL occur when cnt >= MIN_GREEN-1, TB_q == 0 and M_q == 0; otherwise hold.
REQ-017 B_YELLOW -> A_GREEN SHALL occur when cnt == YEL_CYCLES-1.
REQ-018 M_q == 1 SHALL hold B_GREEN indefinitely, regardless of TB_q or cnt.
REQ-019 M_q SHALL have no effect in A_GREEN, A_YELLOW or B_YELLOW; a started yellow always completes.
REQ-020 Input-to-decision latency SHALL be one cycle; the output change SHALL appear on the edge after the decision, i.e. the second rising edge after the input change.
REQ-021 o_LA and o_LB SHALL never be non-red simultaneously in any cycle.
REQ-022 Counter saturation SHALL not cause a wrap-back to 0 or a spurious transition.

Reset
REQ-023 Assertion of i_rstn SHALL immediately force state A_GREEN, cnt 0, TA_q/TB_q/M_q 0, o_LA 2'b00 and o_LB 2'b10, independent of i_clk.
REQ-024 Reset asserted mid-yellow or mid-green SHALL abandon the sequence, with no residual count after release.
REQ-025 After reset release, the first state evaluation SHALL occur on the first rising edge with i_rstn high.

Structure
REQ-026 SHALL place the light encodings (GREEN/YELLOW/RED) and the 2-bit state encodings in a shared package traffic_pkg, reused by the mode FSM bench and the top level.
REQ-027 SHALL implement the dwell counter as sub-module tl_dwell_timer (inputs clear and enable; output 8-bit saturating count).
REQ-028 The top-level traffic system SHALL connect o_M of the upstream mode FSM directly to i_M.

Verification (YEL_CYCLES=5, MIN_GREEN=10)
REQ-029 Reset, then i_TA=1 for 50 cycles -> stays A_GREEN, o_LA=00 and o_LB=10 throughout.
REQ-030 Reset, then i_TA=0 and i_TB=1 -> A_YELLOW entered after 10 cycles of A_GREEN, lasts exactly 5 cycles, then B_GREEN, which holds while i_TB=1.
REQ-031 In B_GREEN, drop i_TB to 0 at cnt=3 -> transition to B_YELLOW waits until cnt=9, then 5 yellow cycles, then A_GREEN.
REQ-032 In B_GREEN, i_M=1 and i_TB=0 for 100 cycles -> stays B_GREEN; i_M=0 -> B_YELLOW two edges later.
REQ-033 i_M=1 raised at A_YELLOW cycle 2 -> yellow completes in 5 cycles, B_GREEN entered and held.
REQ-034 i_rstn pulsed low at B_YELLOW cycle 3 -> outputs go to 00/10 asynchronously, and A_GREEN again lasts at least 10 cycles; the bench checks REQ-021 on every cycle of every scenario.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light and state encodings for the traffic light controller
// Used by the controller, its dwell timer and the surrounding benches.
package traffic_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  localparam int               CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    A_GREEN  = 2'b00,
    A_YELLOW = 2'b01,
    B_GREEN  = 2'b10,
    B_YELLOW = 2'b11
  } tl_state_e;

  // Packed as {LA, LB}; every state keeps at least one street red.
  function automatic logic [3:0] lights_of(input tl_state_e s);
    case (s)
      A_GREEN:  lights_of = {LIGHT_GREEN,  LIGHT_RED};
      A_YELLOW: lights_of = {LIGHT_YELLOW, LIGHT_RED};
      B_GREEN:  lights_of = {LIGHT_RED,    LIGHT_GREEN};
      default:  lights_of = {LIGHT_RED,    LIGHT_YELLOW};
    endcase
  endfunction

endpackage

// File: rtl/tl_dwell_timer.sv
// rtl/tl_dwell_timer.sv - 8-bit saturating dwell counter
// Counts cycles spent in the current light phase; clear wins over enable.
import traffic_pkg::*;

module tl_dwell_timer (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - two-street traffic light controller with parade hold
// Inputs are registered once; lights are a Moore decode of the phase state.
import traffic_pkg::*;

module traffic_light_fsm #(
  parameter int YEL_CYCLES = 5,
  parameter int MIN_GREEN  = 10
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_TA,
  input  logic       i_TB,
  input  logic       i_M,
  output logic [1:0] o_LA,
  output logic [1:0] o_LB
);

  localparam logic [CNT_W-1:0] LP_GRN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LP_YEL_LAST = CNT_W'(YEL_CYCLES - 1);

  logic             r_ta_q;
  logic             r_tb_q;
  logic             r_m_q;
  tl_state_e        r_state;
  tl_state_e        w_next;
  logic [CNT_W-1:0] w_cnt;
  logic             w_green_done;
  logic             w_yel_done;
  logic             w_change;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ta_q  <= 1'b0;
      r_tb_q  <= 1'b0;
      r_m_q   <= 1'b0;
      r_state <= A_GREEN;
    end else begin
      r_ta_q  <= i_TA;
      r_tb_q  <= i_TB;
      r_m_q   <= i_M;
      r_state <= w_next;
    end
  end

  // Saturated count stays >= the green threshold, so saturation never re-arms a hold.
  assign w_green_done = (w_cnt >= LP_GRN_LAST);
  assign w_yel_done   = (w_cnt == LP_YEL_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      A_GREEN:  if (w_green_done && !r_ta_q)           w_next = A_YELLOW;
      A_YELLOW: if (w_yel_done)                        w_next = B_GREEN;
      B_GREEN:  if (w_green_done && !r_tb_q && !r_m_q) w_next = B_YELLOW;
      B_YELLOW: if (w_yel_done)                        w_next = A_GREEN;
      default:                                         w_next = A_GREEN;
    endcase
  end

  assign w_change = (w_next != r_state);

  tl_dwell_timer u_dwell (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_clear  (w_change),
    .i_enable (1'b1),
    .o_cnt    (w_cnt)
  );

  assign {o_LA, o_LB} = lights_of(r_state);

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - directed scenarios plus random traffic against a phase model
// The model tracks which street is green, whether it is yellow and time in phase.
module tb_traffic_light_fsm;

  localparam int YEL  = 5;
  localparam int MING = 10;
  localparam int GRN_L = 0;
  localparam int YEL_L = 1;
  localparam int RED_L = 2;

  logic       i_clk;
  logic       i_rstn;
  logic       i_TA;
  logic       i_TB;
  logic       i_M;
  logic [1:0] o_LA;
  logic [1:0] o_LB;

  traffic_light_fsm #(
    .YEL_CYCLES (YEL),
    .MIN_GREEN  (MING)
  ) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_TA   (i_TA),
    .i_TB   (i_TB),
    .i_M    (i_M),
    .o_LA   (o_LA),
    .o_LB   (o_LB)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  int m_street;
  bit m_yel;
  int m_dwell;
  bit m_qa, m_qb, m_qm;

  task automatic chk_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_street = 0;
    m_yel    = 1'b0;
    m_dwell  = 0;
    m_qa     = 1'b0;
    m_qb     = 1'b0;
    m_qm     = 1'b0;
  endtask

  // One clock edge: decide on previously sampled inputs, then sample the current ones.
  task automatic model_step(input bit ta, input bit tb_in, input bit m);
    bit go;
    if (m_yel)
      go = (m_dwell == YEL - 1);
    else if (m_street == 0)
      go = (m_dwell >= MING - 1) && !m_qa;
    else
      go = (m_dwell >= MING - 1) && !m_qb && !m_qm;
    if (go) begin
      if (m_yel) m_street = 1 - m_street;
      m_yel   = !m_yel;
      m_dwell = 0;
    end else begin
      m_dwell++;
    end
    m_qa = ta;
    m_qb = tb_in;
    m_qm = m;
  endtask

  function automatic int exp_light(input int street);
    if (street != m_street) return RED_L;
    return m_yel ? YEL_L : GRN_L;
  endfunction

  task automatic observe();
    chk_eq("LA", int'(o_LA), exp_light(0));
    chk_eq("LB", int'(o_LB), exp_light(1));
    chk_eq("excl", int'((o_LA != 2'(RED_L)) && (o_LB != 2'(RED_L))), 0);
  endtask

  task automatic cycle(input bit ta, input bit tb_in, input bit m);
    i_TA = ta;
    i_TB = tb_in;
    i_M  = m;
    @(posedge i_clk);
    model_step(ta, tb_in, m);
    #1;
    observe();
  endtask

  task automatic do_reset();
    #2;
    i_rstn = 1'b0;
    #1;
    chk_eq("rst_LA", int'(o_LA), GRN_L);
    chk_eq("rst_LB", int'(o_LB), RED_L);
    model_reset();
    i_TA = 1'b0;
    i_TB = 1'b0;
    i_M  = 1'b0;
    @(posedge i_clk);
    #2;
    i_rstn = 1'b1;
    observe();
  endtask

  // Counts edges until the selected light leaves value lv (bounded).
  task automatic run_until(input bit ta, input bit tb_in, input bit m,
                           input int sel, input int lv, input int bound, output int n);
    n = 0;
    do begin
      cycle(ta, tb_in, m);
      n++;
    end while (((sel == 0) ? int'(o_LA) : int'(o_LB)) == lv && n < bound);
  endtask

  initial begin
    int n;
    bit rm;
    i_rstn = 1'b1;
    i_TA = 1'b0;
    i_TB = 1'b0;
    i_M  = 1'b0;
    model_reset();
    #3;
    i_rstn = 1'b0;
    #1;
    chk_eq("init_LA", int'(o_LA), GRN_L);
    chk_eq("init_LB", int'(o_LB), RED_L);
    @(posedge i_clk);
    #2;
    i_rstn = 1'b1;
    observe();

    // A traffic keeps A green
    repeat (50) cycle(1, 1, 0);
    chk_eq("a_held", int'(o_LA), GRN_L);

    // Normal handover to B, B held while TB=1
    do_reset();
    run_until(0, 1, 0, 0, GRN_L, 300, n);
    chk_eq("a_grn_edges", n, MING);
    run_until(0, 1, 0, 0, YEL_L, 300, n);
    chk_eq("a_yel_edges", n, YEL);
    chk_eq("b_entered", int'(o_LB), GRN_L);
    repeat (40) cycle(0, 1, 0);
    chk_eq("b_held", int'(o_LB), GRN_L);

    // TB drop after min green expired: two-edge latency
    run_until(0, 0, 0, 1, GRN_L, 300, n);
    chk_eq("b_drop_lat", n, 2);
    run_until(0, 0, 0, 1, YEL_L, 300, n);
    chk_eq("b_yel_edges", n, YEL);

    // TB drop at cnt=3 waits for minimum green
    run_until(0, 1, 0, 0, GRN_L, 300, n);
    run_until(0, 1, 0, 0, YEL_L, 300, n);
    repeat (3) cycle(0, 1, 0);
    run_until(0, 0, 0, 1, GRN_L, 300, n);
    chk_eq("b_min_wait", n, MING - 3);
    run_until(0, 0, 0, 1, YEL_L, 300, n);
    chk_eq("b_yel2_edges", n, YEL);
    chk_eq("a_back", int'(o_LA), GRN_L);

    // Parade holds B green; release gives yellow two edges later
    run_until(0, 1, 0, 0, GRN_L, 300, n);
    run_until(0, 1, 0, 0, YEL_L, 300, n);
    repeat (100) cycle(0, 0, 1);
    chk_eq("parade_hold", int'(o_LB), GRN_L);
    run_until(0, 0, 0, 1, GRN_L, 300, n);
    chk_eq("parade_rel", n, 2);
    run_until(0, 0, 0, 1, YEL_L, 300, n);

    // Parade raised mid A-yellow: yellow completes, then B held
    run_until(0, 0, 0, 0, GRN_L, 300, n);
    chk_eq("a_grn3_edges", n, MING);
    repeat (2) cycle(0, 0, 0);
    run_until(0, 0, 1, 0, YEL_L, 300, n);
    chk_eq("yel_completes", n, YEL - 2);
    repeat (60) cycle(0, 0, 1);
    chk_eq("parade_hold2", int'(o_LB), GRN_L);

    // Reset mid B-yellow restarts a full A green
    run_until(0, 0, 0, 1, GRN_L, 300, n);
    repeat (3) cycle(0, 0, 0);
    chk_eq("mid_yel", int'(o_LB), YEL_L);
    do_reset();
    run_until(0, 0, 0, 0, GRN_L, 300, n);
    chk_eq("post_rst_grn", n, MING);

    // Random traffic with sticky parade and occasional resets
    rm = 1'b0;
    repeat (3000) begin
      if (($urandom % 20) == 0) rm = !rm;
      if (($urandom % 300) == 0)
        do_reset();
      else
        cycle(($urandom % 3) == 0, ($urandom % 3) == 0, rm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
